// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// Optional feature macro: PISO_PARITY_EN (appends an even-parity bit to each frame).
package piso_pkg;

   typedef enum logic {IDLE, SHIFT} piso_state_t;

   // Number of bits on sout per accepted word.
   function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial-side signals of the serializer, bundled as one interface.
// The producer/consumer environment uses the master modport, the serializer the slave one.
interface piso_serializer_if #(
   parameter int WIDTH = 8
) ();

   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic             msb_first;
   logic             shift_en;
   logic             sout;
   logic             sout_valid;
   logic             frame_start;
   logic             frame_end;
   logic             busy;

   modport master (
      output s_valid, s_data, msb_first, shift_en,
      input  s_ready, sout, sout_valid, frame_start, frame_end, busy
   );

   modport slave (
      input  s_valid, s_data, msb_first, shift_en,
      output s_ready, sout, sout_valid, frame_start, frame_end, busy
   );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shift register with valid/ready load, per-word bit order,
// shift-enable stall and frame markers. Back-to-back words stream with no idle gap.
// Optional feature macro: PISO_PARITY_EN (even-parity bit after the data bits).
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic              clk,
   input  logic              clr_n,
   piso_serializer_if.slave  bus
);

   localparam int FL = frame_len(WIDTH);

   piso_state_t      state_reg;
   logic [FL-1:0]    sr_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             sout_valid_reg;
   logic             frame_start_reg;
   logic             frame_end_reg;
   logic             busy_reg;

   logic [WIDTH-1:0] data_rev;
   logic [FL-1:0]    load_val;
   logic             accept;

   // Bit-reversed copy of the input word: the register always shifts toward bit 0,
   // so MSB-first order is obtained by reversing at load time.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
         assign data_rev[gi] = bus.s_data[WIDTH-1-gi];
      end
   endgenerate

   // Value loaded into the shift register at accept; bit 0 is the first bit out.
   always_comb begin
      load_val = '0;
`ifdef PISO_PARITY_EN
      load_val = {^bus.s_data, (bus.msb_first ? data_rev : bus.s_data)};
`else
      load_val = bus.msb_first ? data_rev : bus.s_data;
`endif
   end

   assign bus.s_ready = clr_n && ((state_reg == IDLE) || (frame_end_reg && bus.shift_en));
   assign accept      = bus.s_valid && bus.s_ready;

   assign bus.sout        = sr_reg[0];
   assign bus.sout_valid  = sout_valid_reg;
   assign bus.frame_start = frame_start_reg;
   assign bus.frame_end   = frame_end_reg;
   assign bus.busy        = busy_reg;

   // Frame FSM: load on accept, advance one bit per enabled cycle, return to IDLE after the last bit.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state_reg       <= IDLE;
         sr_reg          <= '0;
         cnt_reg         <= '0;
         sout_valid_reg  <= 1'b0;
         frame_start_reg <= 1'b0;
         frame_end_reg   <= 1'b0;
         busy_reg        <= 1'b0;
      end else if (accept) begin
         // Covers both a load from IDLE and the zero-gap reload in a frame's final cycle.
         state_reg       <= SHIFT;
         sr_reg          <= load_val;
         cnt_reg         <= '0;
         sout_valid_reg  <= 1'b1;
         frame_start_reg <= 1'b1;
         frame_end_reg   <= 1'b0;
         busy_reg        <= 1'b1;
      end else if (state_reg == SHIFT && bus.shift_en) begin
         if (frame_end_reg) begin
            state_reg       <= IDLE;
            sr_reg          <= '0;
            cnt_reg         <= '0;
            sout_valid_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_end_reg   <= 1'b0;
            busy_reg        <= 1'b0;
         end else begin
            sr_reg          <= sr_reg >> 1;
            cnt_reg         <= cnt_reg + 1'b1;
            frame_start_reg <= 1'b0;
            frame_end_reg   <= (cnt_reg == CNT_W'(FL - 2));
         end
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed testbench for piso_serializer (WIDTH=8), covering both builds of PISO_PARITY_EN.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
   localparam int TB_FL = 9;
`else
   localparam int TB_FL = 8;
`endif

   logic clk;
   logic clr_n;
   int   n_checks;
   int   n_pass;

   piso_serializer_if #(.WIDTH(8)) bus ();

   piso_serializer #(.WIDTH(8)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compares {sout, sout_valid, frame_start, frame_end, busy} as one value.
   task automatic expect_out(input string tag, input logic so, input logic sv,
                             input logic fs, input logic fe, input logic bz);
      chk(tag, {27'd0, bus.sout, bus.sout_valid, bus.frame_start, bus.frame_end, bus.busy},
               {27'd0, so, sv, fs, fe, bz});
   endtask

   task automatic expect_idle(input string tag);
      expect_out({tag, "_idle_out"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk({tag, "_idle_rdy"}, {31'd0, bus.s_ready}, 32'd1);
   endtask

   task automatic load(input logic [7:0] d, input logic m);
      bus.s_valid   = 1'b1;
      bus.s_data    = d;
      bus.msb_first = m;
      bus.shift_en  = 1'b1;
      tick();
      bus.s_valid   = 1'b0;
      bus.s_data    = ~d;
      bus.msb_first = ~m;
   endtask

   // Walks a frame whose first bit is already on sout. seq holds the data bits in
   // output order (bit 7 first); par is the expected parity bit.
   task automatic check_frame(input string tag, input logic [7:0] seq, input logic par,
                              input int stall_at, input int abort_at,
                              input bit chain, input logic [7:0] nd, input logic nm);
      logic eb;
      for (int i = 0; i < TB_FL; i++) begin
         eb = (i < 8) ? seq[7-i] : par;
         expect_out($sformatf("%s_bit%0d", tag, i), eb, 1'b1, (i == 0), (i == TB_FL - 1), 1'b1);
         if (i == abort_at) begin
            clr_n = 1'b0;
            tick();
            expect_out({tag, "_abort_out"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk({tag, "_abort_rdy"}, {31'd0, bus.s_ready}, 32'd0);
            $display("frame %s aborted at bit %0d", tag, i);
            return;
         end
         if (i == stall_at) begin
            bus.shift_en = 1'b0;
            bus.s_valid  = 1'b1;
            bus.s_data   = 8'h5A;
            for (int k = 0; k < 3; k++) begin
               #1;
               chk($sformatf("%s_stall_rdy%0d", tag, k), {31'd0, bus.s_ready}, 32'd0);
               tick();
               expect_out($sformatf("%s_hold%0d", tag, k), eb, 1'b1, (i == 0), (i == TB_FL - 1), 1'b1);
            end
            bus.shift_en = 1'b1;
            bus.s_valid  = 1'b0;
         end
         if (chain && i == TB_FL - 1) begin
            bus.s_valid   = 1'b1;
            bus.s_data    = nd;
            bus.msb_first = nm;
         end
         #1;
         chk($sformatf("%s_rdy%0d", tag, i), {31'd0, bus.s_ready}, {31'd0, (i == TB_FL - 1)});
         tick();
         bus.s_valid   = 1'b0;
         bus.s_data    = ~bus.s_data;
         bus.msb_first = ~bus.msb_first;
      end
      $display("frame %s complete (%0d bits)", tag, TB_FL);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;

      // Reset held with a pending word: nothing may be accepted.
      clr_n         = 1'b0;
      bus.s_valid   = 1'b1;
      bus.s_data    = 8'hB4;
      bus.msb_first = 1'b1;
      bus.shift_en  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("rst_rdy%0d", k), {31'd0, bus.s_ready}, 32'd0);
         expect_out($sformatf("rst_out%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      bus.s_valid = 1'b0;
      clr_n       = 1'b1;
      #1;
      expect_idle("rst_release");
      $display("reset sequence done");

      // MSB first: B4 -> 1,0,1,1,0,1,0,0 (parity 0)
      load(8'hB4, 1'b1);
      check_frame("msb", 8'hB4, 1'b0, -1, -1, 1'b0, 8'h00, 1'b0);
      expect_idle("msb");

      // LSB first: B4 -> 0,0,1,0,1,1,0,1
      load(8'hB4, 1'b0);
      check_frame("lsb", 8'h2D, 1'b0, -1, -1, 1'b0, 8'h00, 1'b0);
      expect_idle("lsb");

      // Stall for 3 cycles on bit 4 (index 3), with s_valid asserted and ignored.
      load(8'hB4, 1'b1);
      check_frame("stall", 8'hB4, 1'b0, 3, -1, 1'b0, 8'h00, 1'b0);
      expect_idle("stall");

      // Back-to-back: B4 then FF with no gap.
      load(8'hB4, 1'b1);
      check_frame("b2b_a", 8'hB4, 1'b0, -1, -1, 1'b1, 8'hFF, 1'b1);
      check_frame("b2b_b", 8'hFF, 1'b0, -1, -1, 1'b0, 8'h00, 1'b0);
      expect_idle("b2b");

      // Final cycle stalled with s_valid high: no accept, then IDLE.
      load(8'hB4, 1'b0);
      check_frame("noacc", 8'h2D, 1'b0, TB_FL - 1, -1, 1'b0, 8'h00, 1'b0);
      expect_idle("noacc");

      // 07 MSB first: 0,0,0,0,0,1,1,1 then parity 1 when enabled.
      load(8'h07, 1'b1);
      check_frame("w07", 8'h07, 1'b1, -1, -1, 1'b0, 8'h00, 1'b0);
      expect_idle("w07");

      // Reset asserted while bit 5 is on sout.
      load(8'h07, 1'b1);
      check_frame("abort", 8'h07, 1'b1, -1, 4, 1'b0, 8'h00, 1'b0);
      clr_n = 1'b1;
      #1;
      expect_idle("abort");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard bound so a broken design cannot hang the run.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, checks so far %0d/%0d", n_pass, n_checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parametrised parallel-in/serial-out shift register with a valid/ready load handshake, per-word bit order select, shift-enable stall, and frame markers. It accepts a WIDTH-bit word and emits it one bit per enabled clock on `sout`. The next word can be accepted with no idle gap, so a continuous stream is possible. It sits between a word-oriented producer and a bit-serial link or downstream consumer.

Parameters:
- WIDTH, 8, data word width in bits (≥2).
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not to be overridden.

Ports:
- clk  in  1  single clock; all logic on posedge.
- clr_n  in  1  synchronous active-low reset.
- s_valid  in  1  producer has a word on s_data.
- s_ready  out  1  block can accept a word this cycle.
- s_data  in  WIDTH  parallel word.
- msb_first  in  1  bit order for this word: 1 = MSB first, 0 = LSB first. Sampled only at accept.
- shift_en  in  1  advance one bit this cycle. 0 = hold.
- sout  out  1  serial data bit.
- sout_valid  out  1  sout carries a frame bit.
- frame_start  out  1  high while the first bit of a frame is on sout.
- frame_end  out  1  high while the last bit of a frame is on sout.
- busy  out  1  a frame is in progress (state SHIFT).

Behaviour:
- Reset (clr_n=0 at posedge):
  - state=IDLE, shift register=0, counter=0.
  - sout, sout_valid, frame_start, frame_end, busy all 0.
  - s_ready is forced 0 combinationally while clr_n=0.
- States are IDLE and SHIFT.
- Frame length FL = WIDTH bits (WIDTH+1 with PARITY_EN).
- Accept: posedge with s_valid && s_ready.
  - Latches s_data and msb_first, sets counter=0, goes to SHIFT.
  - From the next cycle: sout = first bit, sout_valid=1, frame_start=1.
- Load-to-first-bit latency is 1 cycle. First-bit presentation does not depend on shift_en.
- In SHIFT, bit advance is gated by shift_en:
  - Each posedge with shift_en=1 advances to the next bit: counter+1, register shifts toward the output end.
  - shift_en=0 holds sout, counter and all flags unchanged.
- Output bit order: MSB first gives s_data[WIDTH-1] down to [0]; LSB first gives [0] up to [WIDTH-1].
- frame_end=1 while counter==FL-1.
- s_ready (combinational):
  - in IDLE: s_ready = 1;
  - in SHIFT: s_ready = frame_end && shift_en.
- End of frame at a posedge with frame_end && shift_en:
  - if s_valid=1: the new word is accepted, its first bit appears next cycle with frame_start=1, and state stays SHIFT (zero-gap back-to-back);
  - if s_valid=0: go to IDLE, and sout_valid, busy and sout clear to 0.
- s_valid in SHIFT outside that final cycle is ignored; s_data need not be held.
- A change of msb_first mid-frame has no effect.
- WIDTH=1 is not supported.
- Reset mid-frame aborts the frame immediately with no partial flush. Outputs are 0 the next cycle.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - after the WIDTH data bits, one extra bit is emitted: even parity, the XOR of all latched data bits;
  - FL=WIDTH+1;
  - frame_end marks the parity bit;
  - parity is computed at accept and is independent of bit order.
- Undefined: FL=WIDTH, no parity logic, and frame_end marks the last data bit.

Decomposition:
- Package piso_pkg holds:
  - typedef enum logic {IDLE, SHIFT} piso_state_t;
  - a function returning FL for a given WIDTH, honouring PISO_PARITY_EN.
- Single module; no sub-module is warranted.
- Bit-order muxing is a register-load-time reversal, so the shift direction is fixed.

Test Plan:
- Reset: hold clr_n=0 for 3 cycles with s_valid=1 → s_ready=0 and all outputs 0. After release, s_ready=1 in IDLE.
- MSB first: WIDTH=8, s_data=8'hB4, msb_first=1, shift_en=1 → sout = 1,0,1,1,0,1,0,0 on cycles 1–8 after accept. frame_start on cycle 1, frame_end on cycle 8, then IDLE.
- LSB first: s_data=8'hB4, msb_first=0 → sout = 0,0,1,0,1,1,0,1.
- Stall: shift_en=0 for 3 cycles during bit 4 → that bit is held for 4 cycles in total, counter frozen, and the sequence is otherwise intact.
- Back-to-back: 8'hB4 then 8'hFF, with s_valid high in the frame_end cycle → 16 consecutive valid bits, no gap, frame_start on cycles 1 and 9. With shift_en=0 in that cycle, s_ready=0 and there is no accept.
- PISO_PARITY_EN: s_data=8'h07, msb_first=1 → 9 bits, 0,0,0,0,0,1,1,1 then parity 1. frame_end on bit 9. A reset asserted at bit 5 zeroes outputs next cycle.
